// File: rtl/half_adder.sv
// rtl/half_adder.sv - multi-lane half adder with optional output register and saturating carry counter
module half_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             count_clear,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             w_beat_carry;
  logic [CNT_W-1:0] r_count;

  assign w_sum        = a ^ b;
  assign w_carry      = a & b;
  // Counting looks at the input side so it has the same timing in both modes.
  assign w_beat_carry = in_valid & (|w_carry);

  generate
    if (REGISTERED) begin : gen_reg
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_carry;
      logic             r_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum   <= '0;
          r_carry <= '0;
          r_valid <= 1'b0;
        end else if (in_valid) begin
          r_sum   <= w_sum;
          r_carry <= w_carry;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end

      assign sum       = r_sum;
      assign carry     = r_carry;
      assign out_valid = r_valid;
    end else begin : gen_comb
      assign sum       = w_sum;
      assign carry     = w_carry;
      assign out_valid = in_valid;
    end
  endgenerate

  assign carry_any = |carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (count_clear) begin
      r_count <= '0;
    end else if (w_beat_carry && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign carry_count = r_count;

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - self-checking bench for half_adder in registered and combinational modes
module tb_half_adder;

  localparam int W = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          count_clear = 1'b0;

  logic [W-1:0]  r_sum, r_carry, c_sum, c_carry;
  logic          r_ov, r_any, c_ov, c_any;
  logic [CW-1:0] r_cnt, c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(W), .REGISTERED(1'b1), .CNT_W(CW)) u_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .count_clear(count_clear), .sum(r_sum), .carry(r_carry),
    .out_valid(r_ov), .carry_any(r_any), .carry_count(r_cnt)
  );

  half_adder #(.WIDTH(W), .REGISTERED(1'b0), .CNT_W(CW)) u_comb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .count_clear(count_clear), .sum(c_sum), .carry(c_carry),
    .out_valid(c_ov), .carry_any(c_any), .carry_count(c_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each lane is a 1-bit integer addition whose two result bits are (carry,sum).
  function automatic logic [2*W-1:0] add_lanes(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] res;
    int s;
    res = '0;
    for (int i = 0; i < W; i++) begin
      s = int'(x[i]) + int'(y[i]);
      res[i]     = (s % 2) == 1;
      res[W + i] = s >= 2;
    end
    return res;
  endfunction

  logic [W-1:0] m_sum = '0;
  logic [W-1:0] m_carry = '0;
  logic         m_valid = 1'b0;
  int           m_count = 0;

  always @(posedge clk or posedge rst) begin
    logic [2*W-1:0] r;
    if (rst) begin
      m_sum = '0; m_carry = '0; m_valid = 1'b0; m_count = 0;
    end else begin
      r = add_lanes(a, b);
      if (count_clear) m_count = 0;
      else if (in_valid && r[2*W-1:W] != 0 && m_count < (1 << CW) - 1) m_count = m_count + 1;
      if (in_valid) begin
        m_sum = r[W-1:0]; m_carry = r[2*W-1:W]; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [2*W-1:0] r;
    r = add_lanes(a, b);
    chk("reg_sum", 64'(r_sum), 64'(m_sum));
    chk("reg_carry", 64'(r_carry), 64'(m_carry));
    chk("reg_valid", 64'(r_ov), 64'(m_valid));
    chk("reg_any", 64'(r_any), 64'(m_carry != 0));
    chk("reg_count", 64'(r_cnt), 64'(m_count));
    chk("comb_sum", 64'(c_sum), 64'(r[W-1:0]));
    chk("comb_carry", 64'(c_carry), 64'(r[2*W-1:W]));
    chk("comb_valid", 64'(c_ov), 64'(in_valid));
    chk("comb_any", 64'(c_any), 64'(r[2*W-1:W] != 0));
    chk("comb_count", 64'(c_cnt), 64'(m_count));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic v, input logic clr);
    a = av; b = bv; in_valid = v; count_clear = clr;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    chk("lit_reset_sum", 64'(r_sum), 64'h0);
    chk("lit_reset_valid", 64'(r_ov), 64'h0);
    chk("lit_reset_count", 64'(r_cnt), 64'h0);
    rst = 1'b0;

    // Truth table on lane 0
    drive(4'b0000, 4'b0000, 1'b1, 1'b0); step();
    chk("lit_tt00", 64'({r_sum[0], r_carry[0], r_ov}), 64'b001);
    drive(4'b0000, 4'b0001, 1'b1, 1'b0); step();
    chk("lit_tt01", 64'({r_sum[0], r_carry[0], r_ov}), 64'b101);
    drive(4'b0001, 4'b0000, 1'b1, 1'b0); step();
    chk("lit_tt10", 64'({r_sum[0], r_carry[0], r_ov}), 64'b101);
    drive(4'b0001, 4'b0001, 1'b1, 1'b0); step();
    chk("lit_tt11", 64'({r_sum[0], r_carry[0], r_ov}), 64'b011);
    chk("lit_tt_count", 64'(r_cnt), 64'h1);

    // Hold with in_valid low
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_hold", 64'({r_sum[0], r_carry[0], r_ov}), 64'b010);
      chk("lit_hold_count", 64'(r_cnt), 64'h1);
    end

    // Lane independence
    drive(4'b1100, 4'b1010, 1'b1, 1'b0); step();
    chk("lit_lane_sum", 64'(r_sum), 64'b0110);
    chk("lit_lane_carry", 64'(r_carry), 64'b1000);
    chk("lit_lane_any", 64'(r_any), 64'h1);
    chk("lit_lane_count", 64'(r_cnt), 64'h2);

    // Saturation then clear
    drive(4'b0000, 4'b0000, 1'b0, 1'b1); step();
    chk("lit_clear", 64'(r_cnt), 64'h0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 4'b0001, 1'b1, 1'b0); step();
      chk("lit_sat", 64'(r_cnt), 64'((i < 3) ? i + 1 : 3));
    end
    drive(4'b0001, 4'b0001, 1'b1, 1'b1); step();
    chk("lit_clear_prio", 64'(r_cnt), 64'h0);

    // Asynchronous reset between edges
    drive(4'b0001, 4'b0000, 1'b1, 1'b0); step();
    chk("lit_pre_rst", 64'({r_sum[0], r_ov}), 64'b11);
    #2 rst = 1'b1;
    #1;
    chk("lit_rst_sum", 64'(r_sum), 64'h0);
    chk("lit_rst_carry", 64'(r_carry), 64'h0);
    chk("lit_rst_valid", 64'(r_ov), 64'h0);
    chk("lit_rst_count", 64'({r_cnt, c_cnt}), 64'h0);
    chk("lit_rst_comb_sum", 64'(c_sum), 64'b0001);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b0001, 4'b0001, 1'b1, 1'b0); step();
    chk("lit_post_rst", 64'({r_sum[0], r_carry[0], r_ov}), 64'b011);
    chk("lit_post_rst_count", 64'(r_cnt), 64'h1);

    // Combinational mode sweep, in_valid toggling
    for (int i = 0; i < 4; i++) begin
      drive(W'(i >> 1), W'(i & 1), logic'(i % 2), 1'b0);
      #1;
      chk("lit_comb_sum", 64'(c_sum[0]), 64'((i == 1 || i == 2) ? 1 : 0));
      chk("lit_comb_carry", 64'(c_carry[0]), 64'((i == 3) ? 1 : 0));
      chk("lit_comb_valid", 64'(c_ov), 64'(i % 2));
      #9;
    end
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
